// File: rtl/clk_rst_mon_pkg.sv
// clk_rst_mon_pkg: shared types and constants for the clock/reset monitor
package clk_rst_mon_pkg;

    typedef enum logic [1:0] {
        SYNC,
        HI,
        LO
    } state_e;

    localparam int SYNC_STAGES = 2;
    localparam int PCT_SCALE   = 100;

endpackage

// File: rtl/clk_rst_mon_sync.sv
// clk_rst_mon_sync: synchroniser, edge detector and optional glitch filter (CLK_RST_MON_GLITCH_FILTER_EN)
module clk_rst_mon_sync
    import clk_rst_mon_pkg::*;
(
    input  logic clk_fr,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic chg
);

    logic [SYNC_STAGES-1:0] sh_q, sh_d;
    logic                   lvl_q, lvl_d;
    logic                   chg_q, chg_d;
`ifdef CLK_RST_MON_GLITCH_FILTER_EN
    logic                   cand_q, cand_d;
`endif

    // Shift in the raw input; accepted level changes produce a one-cycle change pulse
    always_comb begin
        sh_d   = {sh_q[SYNC_STAGES-2:0], d};
`ifdef CLK_RST_MON_GLITCH_FILTER_EN
        cand_d = sh_q[SYNC_STAGES-1];
        lvl_d  = (sh_q[SYNC_STAGES-1] == cand_q) ? cand_q : lvl_q;
`else
        lvl_d  = sh_q[SYNC_STAGES-1];
`endif
        chg_d  = lvl_d ^ lvl_q;
    end

    // State registers
    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            sh_q   <= '0;
            lvl_q  <= 1'b0;
            chg_q  <= 1'b0;
`ifdef CLK_RST_MON_GLITCH_FILTER_EN
            cand_q <= 1'b0;
`endif
        end else begin
            sh_q   <= sh_d;
            lvl_q  <= lvl_d;
            chg_q  <= chg_d;
`ifdef CLK_RST_MON_GLITCH_FILTER_EN
            cand_q <= cand_d;
`endif
        end
    end

    assign lvl = lvl_q;
    assign chg = chg_q;

endmodule

// File: rtl/clk_rst_mon.sv
// clk_rst_mon: measures mon_clk phases/period and mon_rst length, flags violations (option: CLK_RST_MON_GLITCH_FILTER_EN)
module clk_rst_mon
    import clk_rst_mon_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int PER_MIN        = 8,
    parameter int PER_MAX        = 12,
    parameter int DUTY_MIN       = 40,
    parameter int DUTY_MAX       = 60,
    parameter int RST_CYCLES_MIN = 5,
    parameter int STUCK_CYC      = 64
) (
    input  logic             clk_fr,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             mon_rst,
    input  logic             err_clr,
    output logic             meas_valid,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] rst_cycles,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_rst_short,
    output logic             clk_stuck
);

    localparam int PW = CNT_W + 7;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] P_MIN = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0] P_MAX = CNT_W'(PER_MAX);
    localparam logic [CNT_W-1:0] R_MIN = CNT_W'(RST_CYCLES_MIN);
    localparam logic [CNT_W-1:0] STUCK = CNT_W'(STUCK_CYC);
    localparam logic [PW-1:0]    D_MIN = PW'(DUTY_MIN);
    localparam logic [PW-1:0]    D_MAX = PW'(DUTY_MAX);
    localparam logic [PW-1:0]    SCALE = PW'(PCT_SCALE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    logic             clk_lvl, clk_chg, rst_lvl, rst_chg;
    logic             clk_rise, clk_fall, rst_rise, rst_fall;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d, idle_q, idle_d, rcnt_q, rcnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, period_cnt_q, period_cnt_d, rst_cycles_q, rst_cycles_d;
    logic             meas_valid_q, meas_valid_d, clk_stuck_q, clk_stuck_d;
    logic             err_period_q, err_period_d, err_duty_q, err_duty_d;
    logic             err_rst_short_q, err_rst_short_d;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] per_sat;
    logic [PW-1:0]    hi_pct, per_dmin, per_dmax;

    clk_rst_mon_sync u_clk_sync (
        .clk_fr (clk_fr),
        .rst    (rst),
        .d      (mon_clk),
        .lvl    (clk_lvl),
        .chg    (clk_chg)
    );

    clk_rst_mon_sync u_rst_sync (
        .clk_fr (clk_fr),
        .rst    (rst),
        .d      (mon_rst),
        .lvl    (rst_lvl),
        .chg    (rst_chg)
    );

    assign clk_rise = clk_chg & clk_lvl;
    assign clk_fall = clk_chg & ~clk_lvl;
    assign rst_rise = rst_chg & rst_lvl;
    assign rst_fall = rst_chg & ~rst_lvl;
    assign sum      = {1'b0, hi_q} + {1'b0, lo_q};
    assign per_sat  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign hi_pct   = PW'(hi_cnt_q) * SCALE;
    assign per_dmin = PW'(period_cnt_q) * D_MIN;
    assign per_dmax = PW'(period_cnt_q) * D_MAX;

    // Clock FSM: phase counting and period measurement; an edge ending a stuck spell resynchronises
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        hi_cnt_d     = hi_cnt_q;
        period_cnt_d = period_cnt_q;
        meas_valid_d = 1'b0;
        case (state_q)
            SYNC: begin
                if (clk_rise) begin
                    state_d = HI;
                    hi_d    = ONE;
                    lo_d    = '0;
                end
            end
            HI: begin
                if (clk_fall) begin
                    state_d = LO;
                    lo_d    = ONE;
                end else begin
                    hi_d = sat_inc(hi_q);
                end
            end
            LO: begin
                if (clk_rise) begin
                    state_d      = HI;
                    period_cnt_d = per_sat;
                    hi_cnt_d     = hi_q;
                    meas_valid_d = 1'b1;
                    hi_d         = ONE;
                    lo_d         = '0;
                end else begin
                    lo_d = sat_inc(lo_q);
                end
            end
            default: state_d = SYNC;
        endcase
        if (clk_stuck_q && clk_chg) begin
            state_d      = SYNC;
            hi_d         = '0;
            lo_d         = '0;
            hi_cnt_d     = hi_cnt_q;
            period_cnt_d = period_cnt_q;
            meas_valid_d = 1'b0;
        end
    end

    // Stuck detection, reset-length tracking and sticky error flags (clear beats set)
    always_comb begin
        idle_d          = clk_chg ? '0 : sat_inc(idle_q);
        clk_stuck_d     = !clk_chg && (clk_stuck_q || idle_d == STUCK);
        rcnt_d          = rst_fall ? '0 : (!rst_lvl && clk_rise) ? sat_inc(rcnt_q) : rcnt_q;
        rst_cycles_d    = rst_rise ? rcnt_q : rst_cycles_q;
        err_period_d    = !err_clr && (err_period_q ||
                          (meas_valid_q && (period_cnt_q < P_MIN || period_cnt_q > P_MAX)));
        err_duty_d      = !err_clr && (err_duty_q ||
                          (meas_valid_q && (hi_pct < per_dmin || hi_pct > per_dmax)));
        err_rst_short_d = !err_clr && (err_rst_short_q || (rst_rise && rcnt_q < R_MIN));
    end

    // State registers
    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            state_q         <= SYNC;
            hi_q            <= '0;
            lo_q            <= '0;
            idle_q          <= '0;
            rcnt_q          <= '0;
            hi_cnt_q        <= '0;
            period_cnt_q    <= '0;
            rst_cycles_q    <= '0;
            meas_valid_q    <= 1'b0;
            clk_stuck_q     <= 1'b0;
            err_period_q    <= 1'b0;
            err_duty_q      <= 1'b0;
            err_rst_short_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
            idle_q          <= idle_d;
            rcnt_q          <= rcnt_d;
            hi_cnt_q        <= hi_cnt_d;
            period_cnt_q    <= period_cnt_d;
            rst_cycles_q    <= rst_cycles_d;
            meas_valid_q    <= meas_valid_d;
            clk_stuck_q     <= clk_stuck_d;
            err_period_q    <= err_period_d;
            err_duty_q      <= err_duty_d;
            err_rst_short_q <= err_rst_short_d;
        end
    end

    assign meas_valid    = meas_valid_q;
    assign hi_cnt        = hi_cnt_q;
    assign period_cnt    = period_cnt_q;
    assign rst_cycles    = rst_cycles_q;
    assign err_period    = err_period_q;
    assign err_duty      = err_duty_q;
    assign err_rst_short = err_rst_short_q;
    assign clk_stuck     = clk_stuck_q;

endmodule

// File: tb/tb_clk_rst_mon.sv
// tb_clk_rst_mon: randomized scoreboard bench for clk_rst_mon (honours CLK_RST_MON_GLITCH_FILTER_EN)
module tb_clk_rst_mon;

`ifdef CLK_RST_MON_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int CNT_W = 16;

    logic             clk_fr = 1'b0, rst = 1'b0, mon_clk = 1'b0, mon_rst = 1'b0, err_clr = 1'b0;
    logic             meas_valid, err_period, err_duty, err_rst_short, clk_stuck;
    logic [CNT_W-1:0] hi_cnt, period_cnt, rst_cycles;

    clk_rst_mon dut (
        .clk_fr        (clk_fr),
        .rst           (rst),
        .mon_clk       (mon_clk),
        .mon_rst       (mon_rst),
        .err_clr       (err_clr),
        .meas_valid    (meas_valid),
        .hi_cnt        (hi_cnt),
        .period_cnt    (period_cnt),
        .rst_cycles    (rst_cycles),
        .err_period    (err_period),
        .err_duty      (err_duty),
        .err_rst_short (err_rst_short),
        .clk_stuck     (clk_stuck)
    );

    always #5 clk_fr = ~clk_fr;

    typedef struct {
        int hi;
        int per;
    } meas_t;

    meas_t exp_q[$];
    int    errors = 0, checks = 0;

    // Reference model: the driven mon_clk waveform as a list of runs (level, length)
    int m_lvl = 0, m_ph = 0, m_cur = 0, m_hi = 0, m_lo = 0, m_rcnt = 0, m_rc = 0;
    bit m_eper = 0, m_eduty = 0, m_ers = 0, rst_next = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // m_ph: 0 = waiting for a rise, 1 = high phase seen, 2 = low phase seen after a high phase
    task automatic model_run(input int lvl, input int len);
        int l;
        l = (FILT && len == 1) ? m_lvl : lvl;
        if (l == m_lvl) begin
            m_cur += len;
            return;
        end
        if (m_lvl == 1) m_hi = m_cur;
        else            m_lo = m_cur;
        if (m_cur > 64) begin
            m_ph = 0;
        end else if (l == 1) begin
            if (m_ph == 2) begin
                exp_q.push_back('{hi: m_hi, per: m_hi + m_lo});
                if (m_hi + m_lo < 8 || m_hi + m_lo > 12) m_eper = 1;
                if (m_hi * 100 < (m_hi + m_lo) * 40 || m_hi * 100 > (m_hi + m_lo) * 60) m_eduty = 1;
            end
            m_ph = 1;
        end else if (m_ph == 1) begin
            m_ph = 2;
        end
        m_lvl = l;
        m_cur = len;
    endtask

    task automatic run(input int lvl, input int len);
        model_run(lvl, len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_fr);
            if (i == 0 && rst_next != mon_rst) begin
                mon_rst = rst_next;
                if (!rst_next) m_rcnt = 0;
                else begin
                    m_rc = m_rcnt;
                    if (m_rcnt < 5) m_ers = 1;
                end
            end
            if (i == 0 && lvl == 1 && mon_clk == 1'b0 && mon_rst == 1'b0) m_rcnt++;
            mon_clk = lvl[0];
        end
    endtask

    task automatic period(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            run(1, h);
            run(0, l);
        end
    endtask

    task automatic period_r(input bit r);
        run(1, 5);
        rst_next = r;
        run(0, 5);
    endtask

    task automatic checkpoint(input string tag);
        run(0, 80);
        chk({tag, ":clk_stuck"}, clk_stuck, 1);
        chk({tag, ":pending_meas"}, exp_q.size(), 0);
        chk({tag, ":err_period"}, err_period, m_eper);
        chk({tag, ":err_duty"}, err_duty, m_eduty);
        chk({tag, ":err_rst_short"}, err_rst_short, m_ers);
        chk({tag, ":rst_cycles"}, rst_cycles, m_rc);
        err_clr = 1'b1;
        run(0, 1);
        err_clr = 1'b0;
        m_eper  = 0;
        m_eduty = 0;
        m_ers   = 0;
        run(0, 3);
        chk({tag, ":err_period_clr"}, err_period, m_eper);
        chk({tag, ":err_duty_clr"}, err_duty, m_eduty);
        chk({tag, ":err_rst_short_clr"}, err_rst_short, m_ers);
    endtask

    // Monitor: every measurement the DUT presents is matched against the scoreboard head
    always @(negedge clk_fr) begin
        meas_t e;
        if (rst && meas_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL meas_extra: got period %0d hi %0d, expected no measurement at %0t",
                         period_cnt, hi_cnt, $time);
            end else begin
                e = exp_q.pop_front();
                chk("meas_period", period_cnt, e.per);
                chk("meas_hi", hi_cnt, e.hi);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int h, l, a;
        repeat (4) @(negedge clk_fr);
        chk("rst:meas_valid", meas_valid, 0);
        chk("rst:hi_cnt", hi_cnt, 0);
        chk("rst:period_cnt", period_cnt, 0);
        chk("rst:rst_cycles", rst_cycles, 0);
        chk("rst:err_period", err_period, 0);
        chk("rst:err_duty", err_duty, 0);
        chk("rst:err_rst_short", err_rst_short, 0);
        chk("rst:clk_stuck", clk_stuck, 0);
        rst = 1'b1;

        period(5, 5, 6);
        period_r(1'b1);
        period(5, 5, 2);
        chk("init:rst_cycles", rst_cycles, m_rc);
        chk("init:err_rst_short", err_rst_short, m_ers);
        checkpoint("p5_5");

        period(3, 3, 6);
        checkpoint("p3_3a");
        period(3, 3, 6);
        checkpoint("p3_3b");

        period(8, 2, 6);
        checkpoint("p8_2");

        period(5, 5, 2);
        period_r(1'b0);
        period(5, 5, 2);
        period_r(1'b1);
        period(5, 5, 1);
        chk("rst3:rst_cycles", rst_cycles, m_rc);
        chk("rst3:err_rst_short", err_rst_short, m_ers);
        period_r(1'b0);
        period(5, 5, 5);
        period_r(1'b1);
        period(5, 5, 1);
        chk("rst6:rst_cycles", rst_cycles, m_rc);
        chk("rst6:err_rst_short", err_rst_short, m_ers);
        checkpoint("rst");

        period(5, 5, 2);
        run(1, 80);
        chk("stuck_hi:clk_stuck", clk_stuck, 1);
        run(0, 5);
        period(5, 5, 3);
        chk("resume:clk_stuck", clk_stuck, 0);
        checkpoint("stuck");

        period(5, 5, 3);
        run(1, 5);
        run(0, 64);
        period(5, 5, 3);
        chk("idle64:clk_stuck", clk_stuck, 0);
        checkpoint("idle64");

        for (int k = 0; k < 6; k++) begin
            run(1, 2);
            run(0, 1);
            run(1, 2);
            run(0, 5);
        end
        checkpoint("glitch");

        for (int k = 0; k < 30; k++) begin
            h = $urandom_range(2, 9);
            l = $urandom_range(2, 9);
            if (h >= 5 && $urandom_range(0, 3) == 0) begin
                a = $urandom_range(2, h - 3);
                run(1, a);
                run(0, 1);
                run(1, h - a - 1);
            end else begin
                run(1, h);
            end
            run(0, l);
        end
        run(0, 80);
        chk("rand:pending_meas", exp_q.size(), 0);
        chk("rand:err_period", err_period, m_eper);
        chk("rand:err_duty", err_duty, m_eduty);
        chk("rand:clk_stuck", clk_stuck, 1);

        rst = 1'b0;
        #1;
        chk("async_rst:clk_stuck", clk_stuck, 0);
        chk("async_rst:err_period", err_period, 0);
        chk("async_rst:err_duty", err_duty, 0);
        chk("async_rst:period_cnt", period_cnt, 0);
        chk("async_rst:rst_cycles", rst_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_rst_mon.md
Name: clk_rst_mon

Overview:
- Checker at the consuming end of the testbench clock/reset path: observes a generated clock (mon_clk) and its active-low reset (mon_rst) as asynchronous data.
- Oversamples both on the free-running clock clk_fr.
- Measures high time, low time and period of mon_clk, and counts mon_clk cycles held in reset.
- Flags period, duty-cycle, stuck-clock and short-reset violations.
- Instantiated beside the clock/reset generator in every block-level bench.

Parameters:
- CNT_W, 16, width of all phase/period/reset counters.
- PER_MIN, 8, minimum legal period in clk_fr cycles.
- PER_MAX, 12, maximum legal period in clk_fr cycles.
- DUTY_MIN, 40, minimum legal high-phase percentage.
- DUTY_MAX, 60, maximum legal high-phase percentage.
- RST_CYCLES_MIN, 5, minimum mon_clk rising edges while mon_rst is low.
- STUCK_CYC, 64, clk_fr cycles without a mon_clk edge before clk_stuck asserts.

Ports:
- clk_fr  in  1  sampling clock (free-running).
- rst  in  1  asynchronous active-low reset.
- mon_clk  in  1  observed clock, asynchronous to clk_fr.
- mon_rst  in  1  observed active-low reset, asynchronous to clk_fr.
- err_clr  in  1  synchronous clear of all sticky error flags.
- meas_valid  out  1  one-cycle pulse when a new period measurement is available.
- hi_cnt  out  CNT_W  last measured high phase, in clk_fr cycles.
- period_cnt  out  CNT_W  last measured period, in clk_fr cycles.
- rst_cycles  out  CNT_W  mon_clk rising edges seen during the last reset pulse.
- err_period  out  1  sticky; period outside [PER_MIN, PER_MAX].
- err_duty  out  1  sticky; duty cycle outside [DUTY_MIN, DUTY_MAX].
- err_rst_short  out  1  sticky; reset pulse shorter than RST_CYCLES_MIN.
- clk_stuck  out  1  level; no mon_clk edge for STUCK_CYC cycles.

Behaviour:
- Clock and reset are fixed: one clock, clk_fr; reset rst is asynchronous and active-low.
- Reset values: every output is 0 and every counter is 0. The FSM is in SYNC.
- Input synchronisation:
  - mon_clk and mon_rst each pass through a 2-flop synchroniser, then a 1-flop edge detector.
  - An input transition is seen as an edge 3 clk_fr cycles later.
- Clock FSM:
  - SYNC: wait for the first rising edge, then go to HI. The first partial period is never measured.
  - HI: hi counter increments every cycle. On a falling edge, go to LO.
  - LO: lo counter increments every cycle. On a rising edge:
    - period_cnt = hi + lo; hi_cnt = hi.
    - meas_valid pulses for 1 cycle.
    - Counters restart at 1. Go to HI.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Checks, evaluated in the cycle meas_valid is high:
  - err_period sets if period_cnt < PER_MIN or period_cnt > PER_MAX.
  - err_duty sets if hi*100 < period*DUTY_MIN or hi*100 > period*DUTY_MAX.
  - Duty products use CNT_W+7-bit unsigned arithmetic, with no truncation.
- Stuck detector:
  - An idle counter counts cycles since the last mon_clk edge of either polarity.
  - clk_stuck asserts when the counter reaches STUCK_CYC.
  - clk_stuck deasserts on the next edge. The FSM then returns to SYNC and discards the partial measurement.
- Reset tracking:
  - While synchronised mon_rst is 0, an rst counter counts mon_clk rising edges. The count restarts at 0 on each falling edge of mon_rst.
  - On mon_rst deassertion, rst_cycles latches the count.
  - In the same cycle, err_rst_short sets if the count < RST_CYCLES_MIN.
  - A mon_rst pulse shorter than the synchroniser delay may be missed. This is acceptable.
- Simultaneous events:
  - Clear vs set: err_clr wins over a set in the same cycle.
  - Edge vs stuck: a mon_clk edge in the cycle clk_stuck would assert suppresses the assertion.
- Reset mid-operation: rst low returns the block to reset state immediately, including sticky flags.
- mon_rst does not reset the clock FSM. Clock measurement continues during an observed reset.

Optional Feature:
- Macro: CLK_RST_MON_GLITCH_FILTER_EN.
- When defined: a synchronised level change is accepted only after it holds for 2 consecutive clk_fr cycles. Single-cycle glitches are ignored and do not affect the counters. Edge latency becomes 4 cycles.
- When undefined: every synchronised change is an edge. Latency is 3 cycles.

Decomposition:
- Package clk_rst_mon_pkg holds:
  - the clock FSM state enum (SYNC, HI, LO);
  - localparam SYNC_STAGES = 2;
  - the percentage scale constant 100.
- Natural sub-module: clk_rst_mon_sync, a synchroniser plus edge detector plus optional glitch filter. It is instantiated twice, for mon_clk and mon_rst.

Test Plan:
- mon_clk 5 cycles high / 5 low, steady → meas_valid every 10 cycles, period_cnt = 10, hi_cnt = 5, no error flags.
- mon_clk 3 high / 3 low → period_cnt = 6, err_period = 1. After err_clr, err_period = 0, then it sets again on the next meas_valid.
- mon_clk 8 high / 2 low → period_cnt = 10, hi_cnt = 8, err_duty = 1, err_period = 0.
- mon_rst low for 3 mon_clk rising edges, then high → rst_cycles = 3, err_rst_short = 1. Repeat with 6 edges → rst_cycles = 6; err_rst_short stays set.
- mon_clk held high for 70 cycles → clk_stuck = 1 at idle count 64. Clock resumes → clk_stuck = 0. First meas_valid comes only after a full period measured from the next rising edge.
- With CLK_RST_MON_GLITCH_FILTER_EN, a 1-cycle low glitch during the high phase of a 5/5 clock → period_cnt stays 10, no extra meas_valid. Without the macro → a spurious short measurement and err_period = 1.
